// File: rtl/ab_input_conditioner.sv
// Two-channel sync + debounce front end for the a/b sequence FSM.
// Ports: clk, rst (async low), en, a_raw/b_raw in; a/b, a_edge/b_edge, valid out.
// Optional macro AB_SINGLE_STEP_EN: a and b never commit on the same edge.
module ab_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT      = 4,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_edge,
  output logic b_edge,
  output logic valid
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SYNC_STAGES + DB_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [CNT_W-1:0]       a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]       b_cnt_q, b_cnt_d;
  logic [CNT_W-1:0]       settle_cnt_q;
  logic [CNT_W-1:0]       settle_cnt_d;
  logic                   a_q, a_d;
  logic                   b_q, b_d;
  logic                   a_edge_q, a_edge_d;
  logic                   b_edge_q, b_edge_d;
  logic                   valid_q, valid_d;
  logic [0:0]             state_q, state_d;

  logic s_a, s_b;
  logic a_diff, b_diff;
  logic a_hit, b_hit;
  logic b_blk;
  logic a_cmt, b_cmt;

  // Chains shift every cycle; en gates
  // only the debounce and settle logic.
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a_raw};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b_raw};
  end

  assign s_a = a_sync_q[SYNC_STAGES-1];
  assign s_b = b_sync_q[SYNC_STAGES-1];

  assign a_diff = s_a != a_q;
  assign b_diff = s_b != b_q;

  assign a_hit = en && a_diff
              && (a_cnt_q == DB_LAST);
  assign b_hit = en && b_diff
              && (b_cnt_q == DB_LAST);

`ifdef AB_SINGLE_STEP_EN
  // a wins a tie; b stays armed at
  // DB_LAST and retries next enabled edge.
  assign b_blk = a_hit && b_hit;
`else
  assign b_blk = 1'b0;
`endif

  assign a_cmt = a_hit;
  assign b_cmt = b_hit && !b_blk;

  always_comb begin
    a_cnt_d = a_cnt_q;
    if (en) begin
      unique case (1'b1)
        !a_diff: a_cnt_d = '0;
        a_hit:   a_cnt_d = '0;
        default: a_cnt_d = a_cnt_q + CNT_ONE;
      endcase
    end
  end

  always_comb begin
    b_cnt_d = b_cnt_q;
    if (en) begin
      unique case (1'b1)
        !b_diff: b_cnt_d = '0;
        b_blk:   b_cnt_d = b_cnt_q;
        b_hit:   b_cnt_d = '0;
        default: b_cnt_d = b_cnt_q + CNT_ONE;
      endcase
    end
  end

  always_comb begin
    a_d = a_cmt ? s_a : a_q;
    b_d = b_cmt ? s_b : b_q;
  end

  // Edges use the pre-edge valid, so a
  // commit on the settling edge stays silent.
  always_comb begin
    a_edge_d = a_cmt && valid_q;
    b_edge_d = b_cmt && valid_q;
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    valid_d      = valid_q;
    unique case (1'b1)
      state_q == ST_SETTLE: begin
        if (en) begin
          settle_cnt_d = settle_cnt_q + CNT_ONE;
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync_q     <= '0;
      b_sync_q     <= '0;
      a_cnt_q      <= '0;
      b_cnt_q      <= '0;
      settle_cnt_q <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      a_edge_q     <= 1'b0;
      b_edge_q     <= 1'b0;
      valid_q      <= 1'b0;
      state_q      <= ST_SETTLE;
    end else begin
      a_sync_q     <= a_sync_d;
      b_sync_q     <= b_sync_d;
      a_cnt_q      <= a_cnt_d;
      b_cnt_q      <= b_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      a_edge_q     <= a_edge_d;
      b_edge_q     <= b_edge_d;
      valid_q      <= valid_d;
      state_q      <= state_d;
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign a_edge = a_edge_q;
  assign b_edge = b_edge_q;
  assign valid  = valid_q;

endmodule
